// File: rtl/nonce_tx_queue_pkg.sv
// Shared definitions for the nonce transmit queue: nonce width, TX FSM encoding
// and a constant-foldable ceil(log2) helper.
package nonce_tx_queue_pkg;

  localparam int unsigned NONCE_W = 32;

  typedef enum logic [1:0] {
    StIdle     = 2'd0,
    StWaitBusy = 2'd1,
    StWaitDone = 2'd2
  } tx_state_t;

  function automatic int unsigned clog2(input int unsigned value);
    int unsigned result;
    int unsigned v;
    result = 0;
    v = (value > 0) ? value - 1 : 0;
    while (v > 0) begin
      result++;
      v = v >> 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/nonce_fifo.sv
// Generic synchronous FIFO with wrap-around pointers and a separate occupancy count.
// DEPTH must be a power of two so the pointers wrap naturally.
module nonce_fifo
  import nonce_tx_queue_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  push_i,
  input  logic [WIDTH-1:0]      wdata_i,
  input  logic                  pop_i,
  output logic [WIDTH-1:0]      rdata_o,
  output logic                  full_o,
  output logic                  empty_o,
  output logic [clog2(DEPTH):0] count_o
);

  localparam int unsigned AddrW = clog2(DEPTH);
  localparam int unsigned CntW  = AddrW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AddrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AddrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]  count_q, count_d;
  logic             do_push, do_pop;

  assign full_o  = (count_q == CntW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign rdata_o = mem_q[rd_ptr_q];

  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + AddrW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + AddrW'(1);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: it is only read while count is non-zero.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/nonce_tx_queue.sv
// Captures per-slave nonce strobes, arbitrates them round-robin into a FIFO and
// serialises the FIFO into the UART transmitter. Define NONCE_DEDUP_EN to drop repeats.
module nonce_tx_queue
  import nonce_tx_queue_pkg::*;
#(
  parameter int unsigned SLAVES = 2,
  parameter int unsigned DEPTH  = 8
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [SLAVES*NONCE_W-1:0] slave_nonces,
  input  logic [SLAVES-1:0]         new_nonces,
  input  logic                      serial_busy,
  output logic                      serial_send,
  output logic [NONCE_W-1:0]        golden_nonce,
  output logic [clog2(DEPTH):0]     fill,
  output logic                      overflow
);

  localparam int unsigned IdxW = (SLAVES > 1) ? clog2(SLAVES) : 1;

  logic [SLAVES-1:0]  pend_q, pend_d;
  logic [NONCE_W-1:0] cap_q [SLAVES];
  logic [NONCE_W-1:0] cap_d [SLAVES];
  logic               overflow_q, overflow_d;
  logic [IdxW-1:0]    ptr_q, ptr_d;

  logic               grant_valid;
  logic [IdxW-1:0]    grant_idx;
  logic [IdxW-1:0]    scan_idx;
  logic [SLAVES-1:0]  grant_oh;
  logic [NONCE_W-1:0] grant_data;

  logic               fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [NONCE_W-1:0] fifo_rdata;

  tx_state_t          state_q, state_d;
  logic               send_q, send_d;
  logic [NONCE_W-1:0] golden_q, golden_d;

  // Scan from the pointer downwards so the slot closest to the pointer wins last.
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    scan_idx    = '0;
    for (int k = SLAVES - 1; k >= 0; k--) begin
      scan_idx = IdxW'((int'(ptr_q) + k) % SLAVES);
      if (pend_q[scan_idx]) begin
        grant_valid = 1'b1;
        grant_idx   = scan_idx;
      end
    end
    if (fifo_full) grant_valid = 1'b0;
  end

  always_comb begin
    grant_oh = '0;
    if (grant_valid) grant_oh[grant_idx] = 1'b1;
  end

  assign grant_data = cap_q[grant_idx];
  assign ptr_d = grant_valid ? IdxW'((int'(grant_idx) + 1) % SLAVES) : ptr_q;

  // A slot being granted this cycle may accept a fresh strobe without loss.
  always_comb begin
    pend_d     = pend_q;
    cap_d      = cap_q;
    overflow_d = overflow_q;
    for (int i = 0; i < SLAVES; i++) begin
      if (new_nonces[i]) begin
        if (!pend_q[i] || grant_oh[i]) begin
          cap_d[i]  = slave_nonces[i*NONCE_W +: NONCE_W];
          pend_d[i] = 1'b1;
        end else begin
          overflow_d = 1'b1;
        end
      end else if (grant_oh[i]) begin
        pend_d[i] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pend_q     <= '0;
      cap_q      <= '{default: '0};
      overflow_q <= 1'b0;
      ptr_q      <= '0;
    end else begin
      pend_q     <= pend_d;
      cap_q      <= cap_d;
      overflow_q <= overflow_d;
      ptr_q      <= ptr_d;
    end
  end

`ifdef NONCE_DEDUP_EN
  logic [NONCE_W-1:0] last_q;
  logic               last_vld_q;

  assign fifo_push = grant_valid && !(last_vld_q && (grant_data == last_q));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      last_q     <= '0;
      last_vld_q <= 1'b0;
    end else if (fifo_push) begin
      last_q     <= grant_data;
      last_vld_q <= 1'b1;
    end
  end
`else
  assign fifo_push = grant_valid;
`endif

  nonce_fifo #(
    .WIDTH(NONCE_W),
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk_i  (clk),
    .rst_ni (reset_n),
    .push_i (fifo_push),
    .wdata_i(grant_data),
    .pop_i  (fifo_pop),
    .rdata_o(fifo_rdata),
    .full_o (fifo_full),
    .empty_o(fifo_empty),
    .count_o(fill)
  );

  // One send per popped entry; busy must be seen high then low before the next.
  always_comb begin
    state_d  = state_q;
    send_d   = 1'b0;
    golden_d = golden_q;
    fifo_pop = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (!fifo_empty && !serial_busy) begin
          fifo_pop = 1'b1;
          golden_d = fifo_rdata;
          send_d   = 1'b1;
          state_d  = StWaitBusy;
        end
      end
      StWaitBusy: if (serial_busy)  state_d = StWaitDone;
      StWaitDone: if (!serial_busy) state_d = StIdle;
      default:    state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= StIdle;
      send_q   <= 1'b0;
      golden_q <= '0;
    end else begin
      state_q  <= state_d;
      send_q   <= send_d;
      golden_q <= golden_d;
    end
  end

  assign serial_send  = send_q;
  assign golden_nonce = golden_q;
  assign overflow     = overflow_q;

endmodule

// File: tb/tb_nonce_tx_queue.sv
// Directed bench for nonce_tx_queue (SLAVES=3, DEPTH=4) with a scoreboard of expected
// transmitted nonces and a bench-side UART busy model.
module tb_nonce_tx_queue;

  logic        clk;
  logic        reset_n;
  logic [95:0] slave_nonces;
  logic [2:0]  new_nonces;
  logic        serial_busy;
  logic        serial_send;
  logic [31:0] golden_nonce;
  logic [2:0]  fill;
  logic        overflow;

  int          errors;
  int          checks;
  int          cyc;
  int          sends;
  int          busy_cnt;
  int          auto_len;
  int          fill_max;
  logic        busy_force;
  logic [31:0] exp_q [$];
  logic [31:0] held;

  nonce_tx_queue #(
    .SLAVES(3),
    .DEPTH (4)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .slave_nonces(slave_nonces),
    .new_nonces  (new_nonces),
    .serial_busy (serial_busy),
    .serial_send (serial_send),
    .golden_nonce(golden_nonce),
    .fill        (fill),
    .overflow    (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign serial_busy = busy_force | (busy_cnt != 0);

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Advance one cycle, sample #1 after the edge, score sends and run the busy model.
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (busy_cnt > 0) busy_cnt--;
    if (serial_send === 1'b1) begin
      sends++;
      check("send_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) check("nonce_order", golden_nonce, exp_q.pop_front());
      if (auto_len > 0) busy_cnt = auto_len;
    end
    if (int'(fill) > fill_max) fill_max = int'(fill);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic strobe(input logic [2:0] mask, input logic [31:0] d0, input logic [31:0] d1,
                        input logic [31:0] d2);
    slave_nonces = {d2, d1, d0};
    new_nonces   = mask;
    tick();
    new_nonces   = '0;
  endtask

  task automatic apply_reset();
    reset_n    = 1'b0;
    new_nonces = '0;
    busy_force = 1'b0;
    busy_cnt   = 0;
    auto_len   = 0;
    exp_q.delete();
    ticks(2);
    reset_n  = 1'b1;
    cyc      = 0;
    sends    = 0;
    fill_max = 0;
  endtask

  initial begin
    errors       = 0;
    checks       = 0;
    cyc          = 0;
    sends        = 0;
    busy_cnt     = 0;
    auto_len     = 0;
    fill_max     = 0;
    busy_force   = 1'b0;
    reset_n      = 1'b0;
    new_nonces   = '0;
    slave_nonces = '0;
    #1;
    apply_reset();

    // Reset state
    check("rst_send", 32'(serial_send), 32'd0);
    check("rst_golden", golden_nonce, 32'd0);
    check("rst_fill", 32'(fill), 32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);

    // Single nonce: strobe at cycle 10, send only in cycle 13
    auto_len = 100;
    while (cyc < 10) tick();
    exp_q.push_back(32'h1234_5678);
    strobe(3'b001, 32'h1234_5678, 32'h0, 32'h0);
    tick();
    check("single_no_early_send", 32'(serial_send), 32'd0);
    tick();
    check("single_send_cycle13", 32'(serial_send), 32'd1);
    held = golden_nonce;
    ticks(50);
    check("single_golden_held", golden_nonce, held);
    ticks(60);
    check("single_send_count", 32'(sends), 32'd1);
    check("single_sb_empty", 32'(exp_q.size()), 32'd0);

    // Simultaneous strobes: A then B, both reach the FIFO
    apply_reset();
    busy_force = 1'b1;
    exp_q.push_back(32'hAAAA_0001);
    exp_q.push_back(32'hBBBB_0002);
    strobe(3'b011, 32'hAAAA_0001, 32'hBBBB_0002, 32'h0);
    ticks(3);
    check("simul_fill_peak", 32'(fill_max), 32'd2);
    auto_len   = 50;
    busy_force = 1'b0;
    ticks(150);
    check("simul_send_count", 32'(sends), 32'd2);
    check("simul_overflow", 32'(overflow), 32'd0);
    check("simul_sb_empty", 32'(exp_q.size()), 32'd0);

    // FIFO full backpressure then overflow on a repeat strobe
    apply_reset();
    busy_force = 1'b1;
    for (int n = 0; n < 5; n++) begin
      exp_q.push_back(32'hF000_0000 + 32'(n));
      strobe(3'b001, 32'hF000_0000 + 32'(n), 32'h0, 32'h0);
      ticks(3);
    end
    check("full_fill", 32'(fill), 32'd4);
    check("full_no_overflow", 32'(overflow), 32'd0);
    strobe(3'b001, 32'hF000_00FF, 32'h0, 32'h0);
    check("full_overflow_set", 32'(overflow), 32'd1);
    auto_len   = 5;
    busy_force = 1'b0;
    ticks(150);
    check("full_send_count", 32'(sends), 32'd5);
    check("full_drained", 32'(fill), 32'd0);
    check("full_sb_empty", 32'(exp_q.size()), 32'd0);
    check("full_overflow_sticky", 32'(overflow), 32'd1);

    // Reset during WAIT_DONE with three entries queued
    apply_reset();
    busy_force = 1'b1;
    strobe(3'b111, 32'hC000_0001, 32'hC000_0002, 32'hC000_0003);
    strobe(3'b001, 32'hC000_0004, 32'h0, 32'h0);
    ticks(6);
    check("mid_fill_before", 32'(fill), 32'd4);
    exp_q.push_back(32'hC000_0001);
    busy_force = 1'b0;
    for (int i = 0; i < 5 && sends == 0; i++) tick();
    busy_force = 1'b1;
    ticks(2);
    check("mid_fill_waitdone", 32'(fill), 32'd3);
    reset_n = 1'b0;
    #1;
    check("mid_rst_send", 32'(serial_send), 32'd0);
    check("mid_rst_golden", golden_nonce, 32'd0);
    check("mid_rst_fill", 32'(fill), 32'd0);
    check("mid_rst_overflow", 32'(overflow), 32'd0);
    apply_reset();
    ticks(30);
    check("mid_no_send_after", 32'(sends), 32'd0);

    // Same nonce from two slaves 20 cycles apart
    apply_reset();
    auto_len = 5;
    exp_q.push_back(32'hDEAD_BEEF);
`ifndef NONCE_DEDUP_EN
    exp_q.push_back(32'hDEAD_BEEF);
`endif
    strobe(3'b001, 32'hDEAD_BEEF, 32'h0, 32'h0);
    ticks(19);
    strobe(3'b010, 32'h0, 32'hDEAD_BEEF, 32'h0);
    ticks(40);
`ifdef NONCE_DEDUP_EN
    check("dedup_send_count", 32'(sends), 32'd1);
`else
    check("dedup_send_count", 32'(sends), 32'd2);
`endif
    check("dedup_overflow", 32'(overflow), 32'd0);
    check("dedup_sb_empty", 32'(exp_q.size()), 32'd0);

    // Round-robin: 0,1,2 then slave 1 alone moves the pointer to 2, then 2,0,1
    apply_reset();
    auto_len = 3;
    exp_q.push_back(32'hA000_0000);
    exp_q.push_back(32'hA000_0001);
    exp_q.push_back(32'hA000_0002);
    strobe(3'b111, 32'hA000_0000, 32'hA000_0001, 32'hA000_0002);
    ticks(40);
    exp_q.push_back(32'hB000_0001);
    strobe(3'b010, 32'h0, 32'hB000_0001, 32'h0);
    ticks(40);
    exp_q.push_back(32'hC100_0002);
    exp_q.push_back(32'hC100_0000);
    exp_q.push_back(32'hC100_0001);
    strobe(3'b111, 32'hC100_0000, 32'hC100_0001, 32'hC100_0002);
    ticks(60);
    check("rr_send_count", 32'(sends), 32'd7);
    check("rr_sb_empty", 32'(exp_q.size()), 32'd0);
    check("rr_overflow", 32'(overflow), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
